// File: rtl/present_pkg.sv
// Shared types and S-box tables for the PRESENT round datapath.
// The state width comes from `SIZE (Constants.sv). The guarded define below only
// covers builds that compile this package before Constants.sv.
`ifndef SIZE
`define SIZE 64
`endif

package present_pkg;

  localparam int NIBBLES = 16;

  typedef logic [3:0]       nibble_t;
  typedef logic [`SIZE-1:0] state_t;

  // Inverse S-box used by decryption.
  localparam nibble_t INV_SBOX [16] = '{
    4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
    4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
  };

  // Forward S-box, only reachable when the block is shared with encryption.
  localparam nibble_t SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } slayer_fsm_t;

endpackage

// File: rtl/Constants.sv
// Project-wide constants shared by the PRESENT datapath blocks.
`ifndef SIZE
`define SIZE 64
`endif

// File: rtl/slayer_dec_sbox4.sv
// Single-nibble S-box lookup. inverse=1 selects the decryption table.
module sbox4
  import present_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       inverse,
  output logic [3:0] sub
);

  // Pure table lookup; no state.
  always_comb begin
    sub = inverse ? INV_SBOX[nib] : SBOX[nib];
  end

endmodule

// File: rtl/slayer_dec.sv
// Iterative inverse S-box layer of the PRESENT decryption round.
// Substitutes NIB_PER_CYCLE nibbles per clock under a start/busy/done handshake.
// Optional macro SLAYER_FWD_EN adds an 'inverse' input so that encryption can
// share the block (forward S-box when inverse=0). The mode is latched at start.
module slayer_dec
  import present_pkg::*;
#(
  parameter int NIB_PER_CYCLE = 1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             start,
`ifdef SLAYER_FWD_EN
  input  logic             inverse,
`endif
  input  logic [`SIZE-1:0] state_in,
  output logic [`SIZE-1:0] state_out,
  output logic             busy,
  output logic             done
);

  localparam int CYCLES = NIBBLES / NIB_PER_CYCLE;
  localparam int CNT_W  = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  // Only divisors of 16 that are powers of two give a whole number of steps.
  if (NIB_PER_CYCLE != 1 && NIB_PER_CYCLE != 2 && NIB_PER_CYCLE != 4 &&
      NIB_PER_CYCLE != 8 && NIB_PER_CYCLE != 16) begin : g_bad_param
    $error("slayer_dec: NIB_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  slayer_fsm_t      fsm;
  logic [CNT_W-1:0] cnt;
  state_t           work;
  state_t           next_work;
  logic             mode;

  nibble_t nib_in  [NIB_PER_CYCLE];
  nibble_t nib_out [NIB_PER_CYCLE];

`ifndef SLAYER_FWD_EN
  // Decryption-only build: the lookup is hard-wired to the inverse table.
  assign mode = 1'b1;
`endif

  // Select the group of nibbles handled in the current step, lowest first.
  always_comb begin
    for (int g = 0; g < NIB_PER_CYCLE; g++) begin
      nib_in[g] = work[(int'(cnt) * NIB_PER_CYCLE + g) * 4 +: 4];
    end
  end

  for (genvar g = 0; g < NIB_PER_CYCLE; g++) begin : g_sbox
    sbox4 u_sbox (
      .nib     (nib_in[g]),
      .inverse (mode),
      .sub     (nib_out[g])
    );
  end

  // Write the substituted group back in place; untouched nibbles pass through.
  always_comb begin
    next_work = work;
    for (int g = 0; g < NIB_PER_CYCLE; g++) begin
      next_work[(int'(cnt) * NIB_PER_CYCLE + g) * 4 +: 4] = nib_out[g];
    end
  end

  // Control FSM plus working/result registers. state_out only changes on
  // completion, so it never exposes a partially substituted state.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      fsm       <= IDLE;
      cnt       <= '0;
      work      <= '0;
      state_out <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef SLAYER_FWD_EN
      mode      <= 1'b1;
`endif
    end else begin
      done <= 1'b0;
      case (fsm)
        IDLE: begin
          if (start) begin
            work <= state_in;
            cnt  <= '0;
            busy <= 1'b1;
            fsm  <= RUN;
`ifdef SLAYER_FWD_EN
            mode <= inverse;
`endif
          end
        end
        RUN: begin
          work <= next_work;
          if (cnt == CNT_W'(CYCLES - 1)) begin
            state_out <= next_work;
            done      <= 1'b1;
            busy      <= 1'b0;
            cnt       <= '0;
            fsm       <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_slayer_dec.sv
// Testbench for slayer_dec: three instances (1, 4 and 16 nibbles per cycle)
// driven from one directed sequence with random data, checked against a
// nibble-wise table model.
module tb_slayer_dec;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [63:0] din;
  logic        inv;
  logic        start_v [3];
  logic [63:0] so      [3];
  logic        busy_v  [3];
  logic        done_v  [3];
  logic [63:0] prev    [3];

  int checks = 0;
  int errors = 0;
  int cyc_tab [3] = '{16, 4, 1};

  logic [3:0] inv_t [16] = '{4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
                             4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA};
  logic [3:0] fwd_t [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                             4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  always #5 Clock = ~Clock;

  slayer_dec #(.NIB_PER_CYCLE(1)) dut1 (
    .Clock(Clock), .Reset(Reset), .start(start_v[0]),
`ifdef SLAYER_FWD_EN
    .inverse(inv),
`endif
    .state_in(din), .state_out(so[0]), .busy(busy_v[0]), .done(done_v[0]));

  slayer_dec #(.NIB_PER_CYCLE(4)) dut4 (
    .Clock(Clock), .Reset(Reset), .start(start_v[1]),
`ifdef SLAYER_FWD_EN
    .inverse(inv),
`endif
    .state_in(din), .state_out(so[1]), .busy(busy_v[1]), .done(done_v[1]));

  slayer_dec #(.NIB_PER_CYCLE(16)) dut16 (
    .Clock(Clock), .Reset(Reset), .start(start_v[2]),
`ifdef SLAYER_FWD_EN
    .inverse(inv),
`endif
    .state_in(din), .state_out(so[2]), .busy(busy_v[2]), .done(done_v[2]));

  function automatic logic [63:0] model(input logic [63:0] x, input logic i);
    logic [63:0] r;
    logic [3:0]  n;
    r = '0;
    for (int k = 0; k < 16; k++) begin
      n = x[k*4 +: 4];
      r[k*4 +: 4] = i ? inv_t[n] : fwd_t[n];
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; start is seen by the next rising edge.
  task automatic launch(input int idx, input logic [63:0] d, input logic i);
    din          = d;
    inv          = i;
    start_v[idx] = 1'b1;
    @(posedge Clock);
    #1;
    start_v[idx] = 1'b0;
    chk("accept_busy", 64'(busy_v[idx]), 64'd1);
    chk("done_single", 64'(done_v[idx]), 64'd0);
  endtask

  // Returns on the falling edge of the done cycle.
  task automatic wait_done(input int idx, input logic [63:0] exp, input bit mid);
    int k    = 0;
    int bcnt = 0;
    bit got  = 1'b0;
    while (!got && k < 40) begin
      @(negedge Clock);
      k++;
      if (busy_v[idx]) bcnt++;
      if (k == 1) din = {$urandom(), $urandom()};
      if (mid && k == 2) begin
        start_v[idx] = 1'b1;
        din          = {$urandom(), $urandom()};
      end
      if (mid && k == 3) start_v[idx] = 1'b0;
      if (done_v[idx]) got = 1'b1;
      else chk("hold_out", so[idx], prev[idx]);
    end
    start_v[idx] = 1'b0;
    chk("done_seen", 64'(got), 64'd1);
    chk("latency", 64'(k - 1), 64'(cyc_tab[idx]));
    chk("busy_cycles", 64'(bcnt), 64'(cyc_tab[idx]));
    chk("result", so[idx], exp);
    prev[idx] = exp;
  endtask

  initial begin
    logic [63:0] v;
    bit          seen;

    Reset = 1'b1;
    din   = '0;
    inv   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0;
      prev[i]    = '0;
    end
    repeat (3) @(negedge Clock);
    for (int i = 0; i < 3; i++) begin
      chk("rst_out", so[i], 64'h0);
      chk("rst_busy", 64'(busy_v[i]), 64'd0);
      chk("rst_done", 64'(done_v[i]), 64'd0);
    end
    Reset = 1'b0;
    @(negedge Clock);

    // Directed vectors, chained so each start lands on the previous done cycle.
    for (int i = 0; i < 3; i++) begin
      launch(i, 64'h0123456789ABCDEF, 1'b1);
      wait_done(i, 64'h5EF8C12DB463079A, 1'b0);
      launch(i, 64'h0000000000000000, 1'b1);
      wait_done(i, 64'h5555555555555555, 1'b0);
      launch(i, 64'hFFFFFFFFFFFFFFFF, 1'b1);
      wait_done(i, 64'hAAAAAAAAAAAAAAAA, 1'b0);
      @(negedge Clock);
    end

    // Random data, with and without an idle gap between operations.
    for (int i = 0; i < 3; i++) begin
      for (int r = 0; r < 4; r++) begin
        v = {$urandom(), $urandom()};
        launch(i, v, 1'b1);
        wait_done(i, model(v, 1'b1), 1'b0);
        if (r[0]) @(negedge Clock);
      end
    end

    // A second start while busy is ignored; a start on the done cycle is taken.
    for (int i = 0; i < 2; i++) begin
      v = {$urandom(), $urandom()};
      launch(i, v, 1'b1);
      wait_done(i, model(v, 1'b1), 1'b1);
      v = {$urandom(), $urandom()};
      launch(i, v, 1'b1);
      wait_done(i, model(v, 1'b1), 1'b0);
    end

    // Reset in the middle of a run aborts it without a done pulse.
    @(negedge Clock);
    launch(0, {$urandom(), $urandom()}, 1'b1);
    repeat (7) @(negedge Clock);
    Reset = 1'b1;
    @(posedge Clock);
    #1;
    chk("abort_busy", 64'(busy_v[0]), 64'd0);
    chk("abort_done", 64'(done_v[0]), 64'd0);
    chk("abort_out", so[0], 64'h0);
    @(negedge Clock);
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) prev[i] = '0;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge Clock);
      if (done_v[0]) seen = 1'b1;
    end
    chk("no_done_after_abort", 64'(seen), 64'd0);
    v = {$urandom(), $urandom()};
    launch(0, v, 1'b1);
    wait_done(0, model(v, 1'b1), 1'b0);

`ifdef SLAYER_FWD_EN
    // Forward substitution and round trip back through the inverse table.
    @(negedge Clock);
    launch(0, 64'h0123456789ABCDEF, 1'b0);
    wait_done(0, 64'hC56B90AD3EF84712, 1'b0);
    launch(0, 64'hC56B90AD3EF84712, 1'b1);
    wait_done(0, 64'h0123456789ABCDEF, 1'b0);
    for (int i = 1; i < 3; i++) begin
      v = {$urandom(), $urandom()};
      launch(i, v, 1'b0);
      wait_done(i, model(v, 1'b0), 1'b0);
      launch(i, model(v, 1'b0), 1'b1);
      wait_done(i, v, 1'b0);
    end
`endif

    @(negedge Clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
